// File: rtl/rf_pkg.sv
// Shared constants and types for the 16x16 register file.
// Imported by the top module and by the read-port sub-module.
package rf_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic {IDLE, SWEEP} rf_state_t;

    typedef logic [DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/rf_read_port.sv
// Registered read port with write-first bypass. The top module supplies the selected
// array word together with same-edge write-hit and sweep-hit flags.
module rf_read_port
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     rd,
    input  rf_word_t arr_word,
    input  logic     wr_hit,
    input  rf_word_t wr_word,
    input  logic     sweep_hit,
    output rf_word_t data
);

    // A write and a sweep clear never share an edge, so their priority is arbitrary.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (rd) begin
            if (wr_hit) begin
                data <= wr_word;
            end else if (sweep_hit) begin
                data <= '0;
            end else begin
                data <= arr_word;
            end
        end
    end

endmodule

// File: rtl/register_file_16x16.sv
// Sixteen-entry register file with one write port, two bypassed read ports,
// and a controller-initiated clear sweep that zeroes one entry per cycle.
module register_file_16x16
    import rf_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              W_wr,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic              Ra_rd,
    input  logic [ADDR_W-1:0] Ra_addr,
    output logic [DATA_W-1:0] Ra_data,
    input  logic              Rb_rd,
    input  logic [ADDR_W-1:0] Rb_addr,
    output logic [DATA_W-1:0] Rb_data,
    input  logic              Clear,
    output logic              Busy,
    output logic              WrDrop
);

    rf_word_t          mem [DEPTH];
    rf_state_t         state;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] idx;
    logic              sweeping;
    logic              wr_en;

    assign sweeping = (state == SWEEP);
    assign wr_en    = W_wr && !sweeping;
    assign Busy     = sweeping;

    always_comb begin
        state_d = state;
        if (state == IDLE) begin
            if (Clear) begin
                state_d = SWEEP;
            end
        end else if (idx == '1) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            WrDrop <= 1'b0;
        end else begin
            state  <= state_d;
            WrDrop <= W_wr && sweeping;
            if (sweeping) begin
                idx <= idx + 1'b1;
            end else begin
                idx <= '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweeping) begin
            mem[idx] <= '0;
        end else if (W_wr) begin
            mem[W_addr] <= W_data;
        end
    end

    rf_read_port u_port_a (
        .clk       (Clk),
        .reset     (Reset),
        .rd        (Ra_rd),
        .arr_word  (mem[Ra_addr]),
        .wr_hit    (wr_en && (W_addr == Ra_addr)),
        .wr_word   (W_data),
        .sweep_hit (sweeping && (idx == Ra_addr)),
        .data      (Ra_data)
    );

    rf_read_port u_port_b (
        .clk       (Clk),
        .reset     (Reset),
        .rd        (Rb_rd),
        .arr_word  (mem[Rb_addr]),
        .wr_hit    (wr_en && (W_addr == Rb_addr)),
        .wr_word   (W_data),
        .sweep_hit (sweeping && (idx == Rb_addr)),
        .data      (Rb_data)
    );

endmodule

// File: tb/tb_register_file_16x16.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle compared
// against an array-based reference model of the register file.
module tb_register_file_16x16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        W_wr = 1'b0;
    logic [3:0]  W_addr = '0;
    logic [15:0] W_data = '0;
    logic        Ra_rd = 1'b0;
    logic [3:0]  Ra_addr = '0;
    logic [15:0] Ra_data;
    logic        Rb_rd = 1'b0;
    logic [3:0]  Rb_addr = '0;
    logic [15:0] Rb_data;
    logic        Clear = 1'b0;
    logic        Busy;
    logic        WrDrop;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents, read registers, drop flag, sweep position (-1 = idle)
    logic [15:0] m_mem [16];
    logic [15:0] m_ra, m_rb;
    logic        m_drop;
    int          m_sweep;

    register_file_16x16 dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .W_wr    (W_wr),
        .W_addr  (W_addr),
        .W_data  (W_data),
        .Ra_rd   (Ra_rd),
        .Ra_addr (Ra_addr),
        .Ra_data (Ra_data),
        .Rb_rd   (Rb_rd),
        .Rb_addr (Rb_addr),
        .Rb_data (Rb_data),
        .Clear   (Clear),
        .Busy    (Busy),
        .WrDrop  (WrDrop)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance past the edge, update the model, compare outputs.
    task automatic cyc(input logic rst, input logic wr, input logic [3:0] wa,
                       input logic [15:0] wd, input logic ard, input logic [3:0] aa,
                       input logic brd, input logic [3:0] ba, input logic clr);
        Reset = rst; W_wr = wr; W_addr = wa; W_data = wd;
        Ra_rd = ard; Ra_addr = aa; Rb_rd = brd; Rb_addr = ba; Clear = clr;
        @(posedge Clk);
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_ra = '0; m_rb = '0; m_drop = 1'b0; m_sweep = -1;
        end else begin
            m_drop = (m_sweep >= 0) && wr;
            if (m_sweep >= 0) m_mem[m_sweep] = '0;
            else if (wr) m_mem[wa] = wd;
            if (ard) m_ra = m_mem[aa];
            if (brd) m_rb = m_mem[ba];
            if (m_sweep >= 0) begin
                m_sweep++;
                if (m_sweep == 16) m_sweep = -1;
            end else if (clr) begin
                m_sweep = 0;
            end
        end
        #1;
        check("ra_data", Ra_data, m_ra);
        check("rb_data", Rb_data, m_rb);
        check("busy", {15'd0, Busy}, {15'd0, (m_sweep >= 0)});
        check("wrdrop", {15'd0, WrDrop}, {15'd0, m_drop});
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int nbusy;

        foreach (m_mem[i]) m_mem[i] = 16'hxxxx;
        m_sweep = -1;

        // Reset, then read every address on both ports
        cyc(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rst_busy", {15'd0, Busy}, 16'd0);
        check("rst_wrdrop", {15'd0, WrDrop}, 16'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(i), 1'b1, 4'(15 - i), 1'b0);
            check("rst_ra", Ra_data, 16'h0000);
            check("rst_rb", Rb_data, 16'h0000);
        end

        // Write then read on a later edge
        cyc(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        check("wr_rd_a", Ra_data, 16'hBEEF);
        check("wr_rd_b", Rb_data, 16'hBEEF);

        // Same-edge bypass on A, neighbour on B keeps old contents
        cyc(1'b0, 1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 1'b1, 4'd6, 1'b0);
        check("bypass_a", Ra_data, 16'h1234);
        check("bypass_b", Rb_data, 16'h6666);

        // Hold: read enables low keep previous data
        cyc(1'b0, 1'b1, 4'd7, 16'h5555, 1'b0, 4'd7, 1'b0, 4'd6, 1'b0);
        check("hold_a", Ra_data, 16'h1234);

        // Fill, then sweep
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'(i), 16'hA5A0 + 16'(i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        end
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        nbusy = Busy ? 1 : 0;
        for (int s = 1; s < 40 && Busy; s++) begin
            if (s == 5) begin
                cyc(1'b0, 1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd15, 1'b1, 4'd1, 1'b1);
                check("sweep_old_a15", Ra_data, 16'hA5AF);
                check("sweep_cleared_b1", Rb_data, 16'h0000);
                check("sweep_wrdrop", {15'd0, WrDrop}, 16'd1);
            end else begin
                cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            end
            if (Busy) nbusy++;
        end
        check("busy_len", 16'(nbusy), 16'd16);
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0);
        check("post_sweep_a15", Ra_data, 16'h0000);
        check("dropped_wr_b0", Rb_data, 16'h0000);

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'(i), 16'hC000 + 16'(i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        end
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int s = 1; s < 8; s++) idle_cyc();
        cyc(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("midrst_busy", {15'd0, Busy}, 16'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(i), 1'b1, 4'(i), 1'b0);
            check("midrst_zero", Ra_data, 16'h0000);
        end
        cyc(1'b0, 1'b1, 4'd2, 16'h00FF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("postrst_nodrop", {15'd0, WrDrop}, 16'd0);
        cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
        check("postrst_rd2", Rb_data, 16'h00FF);

        // Clear held high: back-to-back sweeps, compared cycle by cycle against the model
        for (int s = 0; s < 40; s++) begin
            cyc(1'b0, s[0], 4'($urandom), 16'($urandom), 1'b1, 4'($urandom),
                1'b1, 4'($urandom), 1'b1);
        end

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            cyc(($urandom_range(0, 199) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
                1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file_16x16.md
# register_file_16x16

Sixteen-entry, 16-bit register file that receives the write-back word chosen by the processor's write-back select stage (ALU result or data-memory read data) and supplies the two operand buses for the ALU. It has one synchronous write port, two registered read ports with write-first bypass, and a controller-initiated clear sequencer that zeroes all entries over 16 cycles. It sits between the write-back mux and the ALU in the datapath and is driven by the control unit.

## Interface
- DATA_W, 16, word width of every register and data port
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W = 16 entries
- Clk  input  1  rising-edge clock, single clock domain
- Reset  input  1  synchronous, active-high; sampled on rising Clk
- W_wr  input  1  write enable
- W_addr  input  ADDR_W  write address
- W_data  input  DATA_W  write data (write-back mux output)
- Ra_rd  input  1  read enable, port A
- Ra_addr  input  ADDR_W  read address, port A
- Ra_data  output  DATA_W  registered read data, port A
- Rb_rd  input  1  read enable, port B
- Rb_addr  input  ADDR_W  read address, port B
- Rb_data  output  DATA_W  registered read data, port B
- Clear  input  1  start a clear sweep (level-sampled; acted on only in IDLE)
- Busy  output  1  high while the sweep runs
- WrDrop  output  1  one-cycle pulse: a write was rejected because Busy was high

## Operation
- Reset (any state, including mid-sweep): all 16 entries = 0, Ra_data = Rb_data = 0, Busy = 0, WrDrop = 0, state = IDLE, sweep index = 0. Reset overrides every other input on that edge.
- Write: on an edge with W_wr=1 in IDLE, the entry at W_addr takes W_data. Full DATA_W word; no partial writes.
- Read: on an edge with Rx_rd=1, Rx_data takes the contents of the entry at Rx_addr. With Rx_rd=0, Rx_data holds its previous value.
- Bypass (write-first): if a same-edge write, or a same-edge sweep clear, targets Rx_addr, Rx_data takes the new value (W_data or 0), not the old contents.
- Both read ports are independent and may address the same entry.
- State machine:
  - IDLE: Clear=1 -> SWEEP with index = 0. Busy rises after this edge. A write on this same edge is still accepted, because the state is IDLE on that edge.
  - SWEEP: each edge clears entry[index] and increments index (ADDR_W bits). The edge that clears index 15 returns to IDLE; index wraps to 0.
- In SWEEP:
  - Clear is ignored.
  - Writes are not performed. WrDrop=1 on the cycle after every edge where W_wr=1.
  - Reads proceed normally. An entry not yet swept returns its old value.
- WrDrop is 0 on every other cycle.

## Timing
- Read latency: 1 cycle (address at edge t, data valid after t).
- Write-to-read on a later edge: the new value is visible at the next read.
- Busy is high for exactly 16 cycles per sweep. Entry k is zeroed on the (k+1)th edge after the Clear edge.
- Back-to-back Clear: Clear held high through the sweep starts a new sweep on the first edge back in IDLE, so Busy drops for exactly 1 cycle.
- No combinational path from any input to any output.

## Structure
- Package rf_pkg holds:
  - DATA_W and ADDR_W constants
  - typedef enum logic {IDLE, SWEEP} rf_state_t
  - typedef logic [DATA_W-1:0] rf_word_t
- One sub-module, rf_read_port: registered read with write-first bypass. Its inputs are the array value, the write hit and the sweep hit. It is instantiated twice, for ports A and B.
- The storage array, write logic and sweep FSM live in the top module.

## Test plan
- Reset then read all 16 addresses on both ports -> every Ra_data/Rb_data = 16'h0000; Busy=0, WrDrop=0.
- Write 16'hBEEF to addr 3. Next cycle read addr 3 on A and addr 3 on B -> both 16'hBEEF, 1 cycle after the read edge.
- Same edge: write 16'h1234 to addr 7 and read addr 7 on A -> Ra_data = 16'h1234 (bypass). Port B reading addr 6 returns its old value.
- Fill regs with 16'hA5A0+i, then pulse Clear:
  - Busy high exactly 16 cycles.
  - Read addr 15 at sweep cycle 5 -> 16'hA5AF.
  - Read addr 15 after Busy falls -> 0.
  - Write during Busy -> WrDrop pulse, entry unchanged.
- Reset asserted at sweep cycle 8 with regs partly cleared -> next cycle Busy=0 and all entries 0. A write to addr 2 of 16'h00FF is then accepted (no WrDrop) and reads back 16'h00FF.
